// File: rtl/computation_sequencer_if.sv
// computation_sequencer_if
//   Bundles the prover-control and layer-control signals of the
//   computation_sequencer.
//
//   master modport (sequencer side):
//     inputs  : start, mux_sel_in, layer_ready
//     outputs : layer_en, mux_sel, cur_layer, busy, done, dbg_state,
//               cycles (only when COMP_SEQ_CYCLE_COUNT_EN is defined)
//   slave modport (environment side): the same signals, directions mirrored.
//
//   Handshake: a layer is launched by a one-cycle high pulse on its
//   layer_en bit. The layer then reports completion by holding its
//   layer_ready bit high. A layer is only launched after its ready has been
//   seen high with en low.
//
//   Optional feature macro: COMP_SEQ_CYCLE_COUNT_EN adds the nCycBits
//   parameter and the cycles signal.
interface computation_sequencer_if #(
  parameter int nLayers    = 4,
  parameter int nmuxsels   = 1,
  parameter int nLayerBits = $clog2(nLayers < 2 ? 2 : nLayers)
`ifdef COMP_SEQ_CYCLE_COUNT_EN
  ,
  parameter int nCycBits   = 32
`endif
);
  logic                  start;
  logic [nmuxsels-1:0]   mux_sel_in;
  logic [nLayers-1:0]    layer_ready;
  logic [nLayers-1:0]    layer_en;
  logic [nmuxsels-1:0]   mux_sel;
  logic [nLayerBits-1:0] cur_layer;
  logic                  busy;
  logic                  done;
  logic [2:0]            dbg_state;
`ifdef COMP_SEQ_CYCLE_COUNT_EN
  logic [nCycBits-1:0]   cycles;

  modport master (
    input  start, mux_sel_in, layer_ready,
    output layer_en, mux_sel, cur_layer, busy, done, dbg_state, cycles
  );
  modport slave (
    output start, mux_sel_in, layer_ready,
    input  layer_en, mux_sel, cur_layer, busy, done, dbg_state, cycles
  );
`else
  modport master (
    input  start, mux_sel_in, layer_ready,
    output layer_en, mux_sel, cur_layer, busy, done, dbg_state
  );
  modport slave (
    output start, mux_sel_in, layer_ready,
    input  layer_en, mux_sel, cur_layer, busy, done, dbg_state
  );
`endif
endinterface

// File: rtl/computation_sequencer.sv
// computation_sequencer
//   Runs one arithmetic-circuit evaluation by launching a stack of nLayers
//   computation_layer instances in order (layer 0 first, nLayers-1 last).
//   Each layer is armed (en low, wait for its ready), launched with a
//   one-cycle en pulse, then waited on until its ready returns. The shared
//   mux_sel configuration is captured when a run is accepted and held for
//   the whole run. One start request arriving during a run is queued and
//   begins immediately after the current run's done cycle.
//
//   Ports:
//     clk  - clock
//     rst  - synchronous active-high reset
//     bus  - computation_sequencer_if.master (start, mux_sel_in,
//            layer_ready in; layer_en, mux_sel, cur_layer, busy, done,
//            dbg_state and optional cycles out)
//
//   Optional feature macro: COMP_SEQ_CYCLE_COUNT_EN adds a saturating
//   run-length counter on bus.cycles.
module computation_sequencer #(
  parameter int nLayers    = 4,
  parameter int nmuxsels   = 1,
  parameter int nLayerBits = $clog2(nLayers < 2 ? 2 : nLayers),
  parameter int nCycBits   = 32
) (
  input  logic clk,
  input  logic rst,
  computation_sequencer_if.master bus
);

  localparam int layer_bits_exp = $clog2(nLayers < 2 ? 2 : nLayers);
  localparam logic [nLayerBits-1:0] last_layer = nLayerBits'(nLayers - 1);

  generate
    if (nLayerBits != layer_bits_exp) begin : g_bad_layer_bits
      $error("computation_sequencer: nLayerBits is derived from nLayers and must not be overridden");
    end
    if (nLayers < 1) begin : g_bad_layers
      $error("computation_sequencer: nLayers must be at least 1");
    end
    if (nCycBits < 1) begin : g_bad_cyc_bits
      $error("computation_sequencer: nCycBits must be at least 1");
    end
  endgenerate

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARM    = 3'd1,
    ST_LAUNCH = 3'd2,
    ST_WAIT   = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [nLayerBits-1:0] cur_q, cur_d;
  logic [nmuxsels-1:0]   mux_q, mux_d;
  logic                  pending_q, pending_d;
  logic [nLayers-1:0]    en_q, en_d;
  logic                  busy_q, done_q;
  logic                  cur_ready;

  assign cur_ready = bus.layer_ready[cur_q];

  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    mux_d     = mux_q;
    pending_d = pending_q;
    // Any start seen outside IDLE queues a single follow-up run; repeats
    // simply re-set the same flag.
    if (state_q != ST_IDLE && bus.start) pending_d = 1'b1;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          mux_d   = bus.mux_sel_in;
          cur_d   = '0;
          state_d = ST_ARM;
        end
      end
      ST_ARM: begin
        if (cur_ready) state_d = ST_LAUNCH;
      end
      ST_LAUNCH: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (cur_ready) begin
          if (cur_q == last_layer) begin
            state_d = ST_DONE;
          end else begin
            cur_d   = cur_q + nLayerBits'(1);
            state_d = ST_ARM;
          end
        end
      end
      ST_DONE: begin
        // A start landing in the done cycle itself also chains a new run.
        pending_d = 1'b0;
        cur_d     = '0;
        if (pending_q || bus.start) begin
          mux_d   = bus.mux_sel_in;
          state_d = ST_ARM;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cur_d   = '0;
      end
    endcase
  end

  // layer_en, busy and done are registered from the next state so the
  // outputs carry no combinational path from any input.
  always_comb begin
    en_d = '0;
    if (state_d == ST_LAUNCH) en_d[cur_d] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cur_q     <= '0;
      mux_q     <= '0;
      pending_q <= 1'b0;
      en_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      mux_q     <= mux_d;
      pending_q <= pending_d;
      en_q      <= en_d;
      busy_q    <= (state_d != ST_IDLE);
      done_q    <= (state_d == ST_DONE);
    end
  end

  assign bus.layer_en  = en_q;
  assign bus.mux_sel   = mux_q;
  assign bus.cur_layer = cur_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.dbg_state = state_q;

`ifdef COMP_SEQ_CYCLE_COUNT_EN
  // Run length: cleared on acceptance (IDLE->ARM or DONE->ARM), counts every
  // busy cycle including DONE, saturates, and holds after the run.
  logic                accept;
  logic [nCycBits-1:0] cyc_q;

  assign accept = (state_d == ST_ARM) && (state_q == ST_IDLE || state_q == ST_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q <= '0;
    end else if (accept) begin
      cyc_q <= '0;
    end else if (busy_q && cyc_q != {nCycBits{1'b1}}) begin
      cyc_q <= cyc_q + nCycBits'(1);
    end
  end

  assign bus.cycles = cyc_q;
`endif

endmodule
